// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared timing constants and types for the SVGA 800x600@60 Hz display path
// (40 MHz pixel clock). Counter widths are sized for the longest axis
// (1056 pixel clocks per line).
// ---------------------------------------------------------------------------
package vga_pkg;

    // Horizontal timing, in pixel clocks
    localparam int unsigned H_VISIBLE = 800;
    localparam int unsigned H_FP      = 40;
    localparam int unsigned H_SYNC    = 128;
    localparam int unsigned H_BP      = 88;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;   // 1056

    // Vertical timing, in lines
    localparam int unsigned V_VISIBLE = 600;
    localparam int unsigned V_FP      = 1;
    localparam int unsigned V_SYNC    = 4;
    localparam int unsigned V_BP      = 23;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;   // 628

    // Width shared by the raster counters and the cell counters
    localparam int CNT_W = 11;

    typedef logic [11:0]      rgb_t;   // {R[3:0], G[3:0], B[3:0]}
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Raster counters and sync decode. h_count runs 0..H_TOT-1 and v_count
// advances each time h_count wraps; both wrap together at the end of frame.
// All outputs are combinational decodes of the current counter values.
//
// Ports
//   clk_40mhz  in   pixel clock
//   reset      in   synchronous, active-high; counters return to (0,0)
//   h_visible  out  h_count inside the active columns
//   v_visible  out  v_count inside the active lines
//   visible    out  both of the above
//   line_end   out  last pixel clock of a line (h_count about to wrap)
//   frame_end  out  last pixel clock of a frame (both counters about to wrap)
//   snap       out  first pixel of the first non-visible line
//   hsync_raw  out  h_count inside the horizontal sync pulse
//   vsync_raw  out  v_count inside the vertical sync pulse
// ---------------------------------------------------------------------------
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACT   = H_VISIBLE,
    parameter int unsigned H_FRONT = H_FP,
    parameter int unsigned H_PULSE = H_SYNC,
    parameter int unsigned H_BACK  = H_BP,
    parameter int unsigned V_ACT   = V_VISIBLE,
    parameter int unsigned V_FRONT = V_FP,
    parameter int unsigned V_PULSE = V_SYNC,
    parameter int unsigned V_BACK  = V_BP
) (
    input  logic clk_40mhz,
    input  logic reset,
    output logic h_visible,
    output logic v_visible,
    output logic visible,
    output logic line_end,
    output logic frame_end,
    output logic snap,
    output logic hsync_raw,
    output logic vsync_raw
);

    localparam int unsigned H_TOT = H_ACT + H_FRONT + H_PULSE + H_BACK;
    localparam int unsigned V_TOT = V_ACT + V_FRONT + V_PULSE + V_BACK;

    cnt_t h_count_q, h_count_d;
    cnt_t v_count_q, v_count_d;

    always_comb begin
        line_end  = (h_count_q == cnt_t'(H_TOT - 1));
        frame_end = line_end && (v_count_q == cnt_t'(V_TOT - 1));

        h_count_d = line_end ? '0 : h_count_q + cnt_t'(1);

        v_count_d = v_count_q;
        if (frame_end) begin
            v_count_d = '0;
        end else if (line_end) begin
            v_count_d = v_count_q + cnt_t'(1);
        end

        h_visible = (h_count_q < cnt_t'(H_ACT));
        v_visible = (v_count_q < cnt_t'(V_ACT));
        visible   = h_visible && v_visible;

        hsync_raw = (h_count_q >= cnt_t'(H_ACT + H_FRONT)) &&
                    (h_count_q <  cnt_t'(H_ACT + H_FRONT + H_PULSE));
        vsync_raw = (v_count_q >= cnt_t'(V_ACT + V_FRONT)) &&
                    (v_count_q <  cnt_t'(V_ACT + V_FRONT + V_PULSE));

        // Start of vertical blanking: the shadow grid may be reloaded here
        // without affecting any visible pixel of the current frame.
        snap = (h_count_q == '0) && (v_count_q == cnt_t'(V_ACT));
    end

    always_ff @(posedge clk_40mhz) begin
        if (reset) begin
            h_count_q <= '0;
            v_count_q <= '0;
        end else begin
            h_count_q <= h_count_d;
            v_count_q <= v_count_d;
        end
    end

endmodule

// File: rtl/grid_vga_renderer.sv
// ---------------------------------------------------------------------------
// grid_vga_renderer
// Display stage for the life grid. The asynchronous grid is resynchronised
// through two register stages, copied into a shadow grid once per frame at
// the start of vertical blanking, and scanned out as square cells of
// CELL_SIZE pixels. Cell coordinates are tracked with incrementing counters
// so no divider is needed.
//
// Ports
//   clk_40mhz   in   pixel clock
//   reset       in   synchronous, active-high
//   grid        in   [HEIGHT-1:0][WIDTH-1:0] live cells, asynchronous source
//   hsync       out  horizontal sync, active-high
//   vsync       out  vertical sync, active-high
//   rgb         out  12-bit colour {R,G,B}
//   frame_done  out  one-cycle pulse after the shadow grid is reloaded
//
// The TIM_* parameters default to 800x600@60 Hz; they exist so the raster
// geometry can be scaled down for short simulations.
// ---------------------------------------------------------------------------
module grid_vga_renderer
    import vga_pkg::*;
#(
    parameter int          WIDTH       = 20,
    parameter int          HEIGHT      = 15,
    parameter int          CELL_SIZE   = 40,
    parameter bit          GRID_LINES  = 1'b1,
    parameter rgb_t        ALIVE_RGB   = 12'hFFF,
    parameter rgb_t        DEAD_RGB    = 12'h000,
    parameter rgb_t        LINE_RGB    = 12'h333,
    parameter int unsigned TIM_H_ACT   = H_VISIBLE,
    parameter int unsigned TIM_H_FRONT = H_FP,
    parameter int unsigned TIM_H_PULSE = H_SYNC,
    parameter int unsigned TIM_H_BACK  = H_BP,
    parameter int unsigned TIM_V_ACT   = V_VISIBLE,
    parameter int unsigned TIM_V_FRONT = V_FP,
    parameter int unsigned TIM_V_PULSE = V_SYNC,
    parameter int unsigned TIM_V_BACK  = V_BP
) (
    input  logic                         clk_40mhz,
    input  logic                         reset,
    input  logic [HEIGHT-1:0][WIDTH-1:0] grid,
    output logic                         hsync,
    output logic                         vsync,
    output rgb_t                         rgb,
    output logic                         frame_done
);

    generate
        if ((WIDTH * CELL_SIZE > int'(TIM_H_ACT)) ||
            (HEIGHT * CELL_SIZE > int'(TIM_V_ACT))) begin : g_geom_check
            $error("grid_vga_renderer: grid does not fit inside the visible area");
        end
    endgenerate

    logic h_visible, v_visible, visible;
    logic line_end, frame_end, snap;
    logic hsync_raw, vsync_raw;

    vga_timing #(
        .H_ACT   (TIM_H_ACT),
        .H_FRONT (TIM_H_FRONT),
        .H_PULSE (TIM_H_PULSE),
        .H_BACK  (TIM_H_BACK),
        .V_ACT   (TIM_V_ACT),
        .V_FRONT (TIM_V_FRONT),
        .V_PULSE (TIM_V_PULSE),
        .V_BACK  (TIM_V_BACK)
    ) u_timing (
        .clk_40mhz (clk_40mhz),
        .reset     (reset),
        .h_visible (h_visible),
        .v_visible (v_visible),
        .visible   (visible),
        .line_end  (line_end),
        .frame_end (frame_end),
        .snap      (snap),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw)
    );

    logic [HEIGHT-1:0][WIDTH-1:0] grid_meta_q, grid_meta_d;
    logic [HEIGHT-1:0][WIDTH-1:0] grid_sync_q, grid_sync_d;
    logic [HEIGHT-1:0][WIDTH-1:0] shadow_q,    shadow_d;

    cnt_t px_x_q,   px_x_d;
    cnt_t cell_x_q, cell_x_d;
    cnt_t px_y_q,   px_y_d;
    cnt_t cell_y_q, cell_y_d;

    rgb_t rgb_q,        rgb_d;
    logic hsync_q,      hsync_d;
    logic vsync_q,      vsync_d;
    logic frame_done_q, frame_done_d;

    logic in_grid;
    logic cell_alive;

    // Capture and per-frame snapshot. Multi-bit skew between grid bits is
    // harmless because the source changes far slower than a frame.
    always_comb begin
        grid_meta_d = grid;
        grid_sync_d = grid_meta_q;
        shadow_d    = snap ? grid_sync_q : shadow_q;
    end

    // Column position: px_x counts pixels inside a cell, cell_x counts cells.
    // Both are cleared on line_end so they read 0 while h_count is 0.
    always_comb begin
        px_x_d   = px_x_q;
        cell_x_d = cell_x_q;
        if (line_end) begin
            px_x_d   = '0;
            cell_x_d = '0;
        end else if (h_visible) begin
            if (px_x_q == cnt_t'(CELL_SIZE - 1)) begin
                px_x_d   = '0;
                cell_x_d = cell_x_q + cnt_t'(1);
            end else begin
                px_x_d   = px_x_q + cnt_t'(1);
            end
        end
    end

    // Row position: steps once per visible line, cleared at the frame wrap.
    always_comb begin
        px_y_d   = px_y_q;
        cell_y_d = cell_y_q;
        if (frame_end) begin
            px_y_d   = '0;
            cell_y_d = '0;
        end else if (line_end && v_visible) begin
            if (px_y_q == cnt_t'(CELL_SIZE - 1)) begin
                px_y_d   = '0;
                cell_y_d = cell_y_q + cnt_t'(1);
            end else begin
                px_y_d   = px_y_q + cnt_t'(1);
            end
        end
    end

    // Shadow lookup as an explicit compare-select, so an out-of-range cell
    // index simply yields 0 instead of an undefined bit select.
    always_comb begin
        cell_alive = 1'b0;
        for (int r = 0; r < HEIGHT; r++) begin
            for (int c = 0; c < WIDTH; c++) begin
                if ((cell_y_q == cnt_t'(r)) && (cell_x_q == cnt_t'(c))) begin
                    cell_alive = shadow_q[r][c];
                end
            end
        end
    end

    always_comb begin
        in_grid = (cell_x_q < cnt_t'(WIDTH)) && (cell_y_q < cnt_t'(HEIGHT));

        rgb_d = '0;
        if (!visible) begin
            rgb_d = '0;
        end else if (!in_grid) begin
            rgb_d = '0;
        end else if (GRID_LINES && ((px_x_q == '0) || (px_y_q == '0))) begin
            rgb_d = LINE_RGB;
        end else if (cell_alive) begin
            rgb_d = ALIVE_RGB;
        end else begin
            rgb_d = DEAD_RGB;
        end

        // Syncs share the rgb register stage so all three stay aligned.
        hsync_d      = hsync_raw;
        vsync_d      = vsync_raw;
        frame_done_d = snap;
    end

    always_ff @(posedge clk_40mhz) begin
        if (reset) begin
            grid_meta_q  <= '0;
            grid_sync_q  <= '0;
            shadow_q     <= '0;
            px_x_q       <= '0;
            cell_x_q     <= '0;
            px_y_q       <= '0;
            cell_y_q     <= '0;
            rgb_q        <= '0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            grid_meta_q  <= grid_meta_d;
            grid_sync_q  <= grid_sync_d;
            shadow_q     <= shadow_d;
            px_x_q       <= px_x_d;
            cell_x_q     <= cell_x_d;
            px_y_q       <= px_y_d;
            cell_y_q     <= cell_y_d;
            rgb_q        <= rgb_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rgb        = rgb_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_grid_vga_renderer.sv
// ---------------------------------------------------------------------------
// tb_grid_vga_renderer
// Two renderers share clock and reset:
//   dut_a  scaled-down raster (56x38 clocks), 8x6 grid of 4-pixel cells that
//          does not fill the 40x30 visible area; random grid updates, frame
//          snapshots and a reset issued inside the sync pulses.
//   dut_b  full 800x600 default geometry; checks the first lines of raster
//          timing and the grid-line pattern of the empty shadow grid.
// Each cycle a reference model derives the expected outputs from the raster
// position (plain division/modulo of a cycle count) and queues them; a
// monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_grid_vga_renderer;

    // Geometry of dut_a
    localparam int HA = 40, HF = 4, HS = 8, HB = 4;
    localparam int VA = 30, VF = 1, VS = 4, VB = 3;
    localparam int HT_A = HA + HF + HS + HB;      // 56
    localparam int VT_A = VA + VF + VS + VB;      // 38
    localparam int FRAME_A = HT_A * VT_A;         // 2128
    localparam int W_A = 8, H_A = 6, C_A = 4;
    localparam logic [11:0] ALIVE_A = 12'hFFF;
    localparam logic [11:0] DEAD_A  = 12'h5A2;
    localparam logic [11:0] LINE_A  = 12'h333;

    // Geometry of dut_b (defaults)
    localparam int HT_B = 1056, VT_B = 628;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic [H_A-1:0][W_A-1:0] grid_a;
    logic [14:0][19:0]     grid_b;
    logic                  hs_a, vs_a, fd_a;
    logic [11:0]           rgb_a;
    logic                  hs_b, vs_b, fd_b;
    logic [11:0]           rgb_b;

    grid_vga_renderer #(
        .WIDTH(W_A), .HEIGHT(H_A), .CELL_SIZE(C_A), .GRID_LINES(1'b1),
        .ALIVE_RGB(ALIVE_A), .DEAD_RGB(DEAD_A), .LINE_RGB(LINE_A),
        .TIM_H_ACT(HA), .TIM_H_FRONT(HF), .TIM_H_PULSE(HS), .TIM_H_BACK(HB),
        .TIM_V_ACT(VA), .TIM_V_FRONT(VF), .TIM_V_PULSE(VS), .TIM_V_BACK(VB)
    ) dut_a (
        .clk_40mhz(clk), .reset(reset), .grid(grid_a),
        .hsync(hs_a), .vsync(vs_a), .rgb(rgb_a), .frame_done(fd_a)
    );

    grid_vga_renderer dut_b (
        .clk_40mhz(clk), .reset(reset), .grid(grid_b),
        .hsync(hs_b), .vsync(vs_b), .rgb(rgb_b), .frame_done(fd_b)
    );

    typedef struct {
        int          h;
        int          v;
        logic        fd;
        logic [13:0] hvr;   // {hsync, vsync, rgb}
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Expected {hsync, vsync, rgb} for raster position (h, v).
    function automatic logic [13:0] ref_out(
        int h, int v, int hv, int hs0, int hs1, int vv, int vs0, int vs1,
        int cs, int w, int ht, logic [11:0] line_c, logic [11:0] alive_c,
        logic [11:0] dead_c, bit alive);
        logic [11:0] c;
        logic hs, vs;
        c = 12'h000;
        if (h < hv && v < vv) begin
            if ((h / cs) < w && (v / cs) < ht) begin
                if ((h % cs) == 0 || (v % cs) == 0) c = line_c;
                else if (alive)                     c = alive_c;
                else                                c = dead_c;
            end
        end
        hs = (h >= hs0) && (h < hs1);
        vs = (v >= vs0) && (v < vs1);
        return {hs, vs, c};
    endfunction

    // ---------------- reference model ----------------
    bit                      started = 1'b0;
    int                      t_a = 0, t_b = 0;
    int                      n_resets = 0;
    int                      fd_expected = 0;
    logic [H_A-1:0][W_A-1:0] shadow_m, hist1, hist2;

    always @(posedge clk) begin
        exp_t e;
        int h, v;
        bit al;
        if (reset) begin
            started  = 1'b1;
            t_a      = 0;
            t_b      = 0;
            n_resets = n_resets + 1;
            shadow_m = '0;
            hist1    = '0;
            hist2    = '0;
            e.h = -1; e.v = -1; e.fd = 1'b0; e.hvr = '0;
            q_a.push_back(e);
            q_b.push_back(e);
        end else if (started) begin
            h = t_a % HT_A;
            v = (t_a / HT_A) % VT_A;
            al = 1'b0;
            if (h < HA && v < VA && (h / C_A) < W_A && (v / C_A) < H_A)
                al = shadow_m[v / C_A][h / C_A];
            e.h = h; e.v = v;
            e.fd  = (h == 0 && v == VA);
            e.hvr = ref_out(h, v, HA, HA + HF, HA + HF + HS, VA, VA + VF, VA + VF + VS,
                            C_A, W_A, H_A, LINE_A, ALIVE_A, DEAD_A, al);
            q_a.push_back(e);
            if (e.fd) begin
                fd_expected = fd_expected + 1;
                // grid value seen two clocks ago is what the capture stages hold
                shadow_m = hist2;
            end
            hist2 = hist1;
            hist1 = grid_a;
            t_a   = t_a + 1;

            // dut_b never reaches its first snapshot here, and its grid is all
            // dead anyway, so its cells always render as dead.
            h = t_b % HT_B;
            v = (t_b / HT_B) % VT_B;
            e.h = h; e.v = v;
            e.fd  = (h == 0 && v == 600);
            e.hvr = ref_out(h, v, 800, 840, 968, 600, 601, 605, 40, 20, 15,
                            12'h333, 12'hFFF, 12'h000, 1'b0);
            q_b.push_back(e);
            t_b = t_b + 1;
        end
    end

    // ---------------- monitor ----------------
    int mon_cyc = 0;
    int last_fd_cyc = -1;
    int last_fd_epoch = -1;
    int fd_seen = 0;

    always @(negedge clk) begin
        exp_t e;
        mon_cyc = mon_cyc + 1;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            n_checks = n_checks + 1;
            if ({fd_a, hs_a, vs_a, rgb_a} !== {e.fd, e.hvr}) begin
                n_fail = n_fail + 1;
                if (n_fail <= 20)
                    $display("FAIL pix_a h=%0d v=%0d got fd/hs/vs/rgb=%b/%b/%b/%03h want %b/%b/%b/%03h",
                             e.h, e.v, fd_a, hs_a, vs_a, rgb_a, e.fd, e.hvr[13], e.hvr[12], e.hvr[11:0]);
            end
            if (fd_a === 1'b1) begin
                fd_seen = fd_seen + 1;
                $display("frame_done a at cycle %0d", mon_cyc);
                if (last_fd_cyc >= 0 && last_fd_epoch == n_resets) begin
                    n_checks = n_checks + 1;
                    if (mon_cyc - last_fd_cyc != FRAME_A) begin
                        n_fail = n_fail + 1;
                        $display("FAIL fd_period got %0d want %0d", mon_cyc - last_fd_cyc, FRAME_A);
                    end
                end
                last_fd_cyc   = mon_cyc;
                last_fd_epoch = n_resets;
            end
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            n_checks = n_checks + 1;
            if ({fd_b, hs_b, vs_b, rgb_b} !== {e.fd, e.hvr}) begin
                n_fail = n_fail + 1;
                if (n_fail <= 20)
                    $display("FAIL pix_b h=%0d v=%0d got fd/hs/vs/rgb=%b/%b/%b/%03h want %b/%b/%b/%03h",
                             e.h, e.v, fd_b, hs_b, vs_b, rgb_b, e.fd, e.hvr[13], e.hvr[12], e.hvr[11:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] rnd;
        int          wait_c;
        bit          hit;
        reset  = 1'b1;
        grid_a = '0;
        grid_b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 12; k++) begin
            wait_c = $urandom_range(FRAME_A / 2, FRAME_A + FRAME_A / 2);
            repeat (wait_c) @(negedge clk);
            rnd = {$urandom(), $urandom()};
            case (k)
                0: begin grid_a = '0; grid_a[0][0] = 1'b1; end
                1: grid_a = '0;
                2: grid_a = '1;
                3: begin grid_a = '0; grid_a[H_A-1][W_A-1] = 1'b1; end
                default: grid_a = rnd[H_A*W_A-1:0];
            endcase
            $display("grid update %0d at model cycle %0d -> %h", k, t_a, grid_a);

            if (k == 6) begin
                // reset while both sync pulses are active
                hit = 1'b0;
                for (int i = 0; i < 3 * FRAME_A && !hit; i++) begin
                    if ((t_a % HT_A) == HA + HF + 2 && ((t_a / HT_A) % VT_A) == VA + VF + 1)
                        hit = 1'b1;
                    else
                        @(negedge clk);
                end
                n_checks = n_checks + 1;
                if (!hit) begin
                    n_fail = n_fail + 1;
                    $display("FAIL midsync_reset_wait got timeout want sync position");
                end else begin
                    $display("mid-sync reset at model cycle %0d", t_a);
                    reset = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                end
            end
        end

        repeat (2 * FRAME_A) @(negedge clk);

        n_checks = n_checks + 1;
        if (fd_seen != fd_expected || fd_expected < 8) begin
            n_fail = n_fail + 1;
            $display("FAIL frame_done_count got %0d want %0d (min 8)", fd_seen, fd_expected);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/grid_vga_renderer.md
# grid_vga_renderer

Downstream display stage for the life grid. Snapshots the `WIDTH`×`HEIGHT` cell grid once per frame and generates 800×600@60 Hz SVGA timing. Scans the grid out as square cells of `CELL_SIZE` pixels, producing 12-bit RGB plus positive-polarity syncs for the VGA DAC pins.

## Interface
- `WIDTH`, 20, grid columns
- `HEIGHT`, 15, grid rows
- `CELL_SIZE`, 40, pixels per cell edge; requires `WIDTH*CELL_SIZE ≤ 800` and `HEIGHT*CELL_SIZE ≤ 600` (elaboration-time assertion)
- `GRID_LINES`, 1, draw a 1-pixel line at the top-left edge of every cell
- `ALIVE_RGB`, 12'hFFF, colour of a live cell
- `DEAD_RGB`, 12'h000, colour of a dead cell
- `LINE_RGB`, 12'h333, grid-line colour
- `clk_40mhz`, in, 1, pixel clock; single clock for the whole block
- `reset`, in, 1, synchronous, active-high
- `grid`, in, `[HEIGHT-1:0][WIDTH-1:0]`, live cell state from the life core; updates asynchronously to `clk_40mhz`
- `hsync`, out, 1, horizontal sync, active-high
- `vsync`, out, 1, vertical sync, active-high
- `rgb`, out, 12, {R[3:0],G[3:0],B[3:0]}
- `frame_done`, out, 1, one-cycle pulse when the shadow grid is loaded

## Operation
- **Counters.**
  - `h_count` 0..1055: visible 0–799, front porch 800–839, sync 840–967, back porch 968–1055.
  - `v_count` 0..627: visible 0–599, front porch 600, sync 601–604, back porch 605–627.
  - `v_count` advances when `h_count` wraps 1055→0.
- **Input capture.** `grid` passes through two register stages (`grid_meta`, `grid_sync`) every cycle.
- **Snapshot.** At `h_count==0 && v_count==600`:
  - `shadow` ← `grid_sync`.
  - `frame_done` pulses on the following cycle.
  - `shadow` is constant for the whole visible region, so there is no tearing.
- **Cell addressing, no dividers.**
  - `px_x` 0..`CELL_SIZE`-1 and `cell_x` both reset to 0 at `h_count==0`. `px_x` increments during visible `h`. On `px_x==CELL_SIZE-1`, `px_x`→0 and `cell_x`+1.
  - `px_y`/`cell_y` follow the same rule, stepping at `h_count==1055` while `v_count<600`, and reset to 0 when `v_count` wraps 627→0.
- **Pixel colour (registered).** Evaluated in this priority order:
  1. blank (`h≥800` or `v≥600`) → 0
  2. outside grid (`cell_x≥WIDTH` or `cell_y≥HEIGHT`) → 0
  3. `GRID_LINES && (px_x==0 || px_y==0)` → `LINE_RGB`
  4. `shadow[cell_y][cell_x]` → `ALIVE_RGB`, else `DEAD_RGB`
- **Syncs.** `hsync` = (840≤h≤967); `vsync` = (601≤v≤604). Both are registered in the same stage as `rgb`.

## Timing
- Latency: outputs at cycle t+1 reflect the counters at cycle t. `rgb`, `hsync` and `vsync` are mutually aligned.
- A change on `grid` reaches the screen after 2 sync cycles plus the wait to the next snapshot, i.e. at most one frame (663 168 cycles) plus 3.
- Frame period is exactly 1056×628 = 663 168 cycles; `frame_done` has the same period.
- Reset (any cycle, including mid-line or mid-sync):
  - next cycle: all counters 0, `shadow` 0, sync stages 0, `hsync`=0, `vsync`=0, `rgb`=0, `frame_done`=0
  - the first snapshot follows 600×1056 cycles after reset release.
- Simultaneous events:
  - The `h` wrap and the `v` wrap on the same cycle (1055,627) → (0,0).
  - A snapshot coinciding with a `grid` change captures the `grid_sync` value present that cycle; no partial update is allowed beyond the two-stage capture.
- The upstream `grid` rate is far slower than a frame; multi-bit skew is tolerated by design.

## Structure
- Package `vga_pkg`:
  - `H_VISIBLE`/`H_FP`/`H_SYNC`/`H_BP`/`H_TOTAL`
  - `V_*` equivalents
  - `typedef logic [11:0] rgb_t`
- Sub-module `vga_timing`: owns `h_count`/`v_count` and sync decode, and outputs `visible`, `line_end`, `frame_end` and `snap`.
- The renderer instantiates `vga_timing` and adds capture, `shadow` and the cell pipeline.

## Test plan
- **Reset and sync timing.** Reset for 3 cycles, then run 2 frames → `hsync` high for 128 cycles every 1056; `vsync` high for 4 lines every 628; `frame_done` period 663 168.
- **Single live cell.** `grid` all 0 except `[0][0]`=1, `GRID_LINES`=0 → `rgb`=FFF for h 0–39 on lines 0–39 of the frame after the snapshot, 000 elsewhere.
- **Grid lines.** `GRID_LINES`=1, all dead → `rgb`=333 at h∈{0,40,…,760} on every visible line and on all of lines {0,40,…,560}; 000 otherwise.
- **Snapshot isolation.** Toggle `grid[7][10]` at v=300 → unchanged for the rest of the frame; visible at pixel (400..439, 280..319) only in the next frame.
- **Mid-frame reset.** Assert at h=900, v=602 → next cycle `hsync`=`vsync`=0, `rgb`=0, counters (0,0); first snapshot 633 600 cycles after release.
- **Non-filling grid.** `WIDTH`=10, `HEIGHT`=5, all alive → `rgb`=0 for h≥400 or v≥200 in the visible region.
